// File: rtl/mod16_seq_ctrl.sv
// mod16_seq_ctrl: handshake/sequencing stage around a combinational modulo unit.
// Operands are registered on accept and held on mod_a/mod_b until the next accept.
// The remainder is captured after a fixed settle window, which lets the divide
// path be timed as a multicycle path.
// Optional statistics counters are built when MOD16_SEQ_STATS_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | in_ready high, waiting for an operand pair
// S_WAIT | operands driven to the modulo unit, settle timer running
// S_DONE | remainder captured, out_valid high until out_ready

module mod16_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] mod_a,
  output logic [DATA_WIDTH-1:0] mod_b,
  input  logic [DATA_WIDTH-1:0] mod_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  dz_out
`ifdef MOD16_SEQ_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           dz_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // The settle timer is a 4-bit down-counter; capture happens on terminal count.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  // Sequencing FSM with registered handshake outputs and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      rem_out    <= '0;
      dz_out     <= 1'b0;
      mod_a      <= '0;
      mod_b      <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mod_a      <= a_in;
            mod_b      <= b_in;
            settle_cnt <= SETTLE_LOAD;
            in_ready   <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_cnt == 4'd0) begin
            // For a zero divisor the modulo unit output is undefined, so the
            // dividend is returned instead and mod_y is never looked at.
            if (mod_b == '0) begin
              rem_out <= mod_a;
              dz_out  <= 1'b1;
            end else begin
              rem_out <= mod_y;
              dz_out  <= 1'b0;
            end
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD16_SEQ_STATS_EN
  // Count completed output handshakes, and those that carried a zero divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      dz_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
      if (dz_out) begin
        dz_count <= dz_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod16_seq_ctrl.sv
// Scoreboard bench for mod16_seq_ctrl: an input monitor pushes the expected
// remainder for every accepted pair, an output monitor pops on each handshake.
module tb_mod16_seq_ctrl;
  localparam int DW     = 16;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic [DW-1:0] mod_a;
  logic [DW-1:0] mod_b;
  logic [DW-1:0] mod_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] rem_out;
  logic          dz_out;
`ifdef MOD16_SEQ_STATS_EN
  logic [15:0]   op_count;
  logic [15:0]   dz_count;
`endif

  mod16_seq_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mod_a     (mod_a),
    .mod_b     (mod_b),
    .mod_y     (mod_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rem_out   (rem_out),
    .dz_out    (dz_out)
`ifdef MOD16_SEQ_STATS_EN
    ,
    .op_count  (op_count),
    .dz_count  (dz_count)
`endif
  );

  // Behavioural modulo unit; undefined output for a zero divisor.
  assign mod_y = (mod_b == '0) ? 'x : mod_a % mod_b;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rem;
    logic          dz;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            acc_edge = 0;
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic          armed = 1'b0;
  logic          prev_ov = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DW-1:0] prev_rem = '0;
  logic          prev_dz = 1'b0;
  logic [DW-1:0] held_a = '0;
  logic [DW-1:0] held_b = '0;
  logic [15:0]   m_op = '0;
  logic [15:0]   m_dz = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned remainder, or the dividend itself for a zero divisor.
  function automatic exp_t ref_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      e.rem = a % b;
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: samples on the falling edge, i.e. the values the next rising edge sees.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      held_a  = '0;
      held_b  = '0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
      m_op    = '0;
      m_dz    = '0;
      armed   = 1'b1;
    end else if (armed) begin
      check("mod_a_hold", 32'(mod_a), 32'(held_a));
      check("mod_b_hold", 32'(mod_b), 32'(held_b));
      check("ready_valid_excl", 32'(in_ready && out_valid), 32'd0);
      if (prev_hs) check("idle_after_hs", 32'({in_ready, out_valid}), 32'b10);
      if (out_valid && !prev_ov) check("latency", 32'(cyc - acc_edge), 32'(SETTLE));
      if (out_valid && prev_ov) begin
        check("rem_hold", 32'(rem_out), 32'(prev_rem));
        check("dz_hold", 32'(dz_out), 32'(prev_dz));
      end
`ifdef MOD16_SEQ_STATS_EN
      check("op_count", 32'(op_count), 32'(m_op));
      check("dz_count", 32'(dz_count), 32'(m_dz));
`endif
      if (out_valid && out_ready) begin
        check("result_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rem_out", 32'(rem_out), 32'(e.rem));
          check("dz_out", 32'(dz_out), 32'(e.dz));
          check("rem_known", 32'($isunknown(rem_out)), 32'd0);
          m_op = m_op + 16'd1;
          if (e.dz) m_dz = m_dz + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_mod(a_in, b_in));
        acc_edge = cyc + 1;
        held_a   = a_in;
        held_b   = b_in;
      end
      prev_ov  = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_rem = rem_out;
      prev_dz  = dz_out;
    end
  end

  // Consumer side: out_ready pattern selected by ready_mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("accept_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = DW'($urandom);
    b_in     = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && sb.size() == 0) && n < 200);
    check("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rem_out", 32'(rem_out), 32'd0);
    check("rst_dz_out", 32'(dz_out), 32'd0);
    check("rst_mod_a", 32'(mod_a), 32'd0);
    check("rst_mod_b", 32'(mod_b), 32'd0);

    ready_mode = 0;
    send(16'd100, 16'd7);
    wait_idle();
    send(16'h1234, 16'd0);
    wait_idle();
    send(16'hFFFF, 16'd1);
    send(16'd3, 16'hFFFF);
    send(16'hFFFF, 16'hFFFF);
    wait_idle();

    // Backpressure: result held while new operands wait on in_valid.
    ready_mode = 2;
    send(16'd47, 16'd6);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = 16'd50;
    b_in     = 16'd8;
    repeat (10) begin
      @(negedge clk);
      check("bp_rem", 32'(rem_out), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_mod_a", 32'(mod_a), 32'd47);
      check("bp_mod_b", 32'(mod_b), 32'd6);
    end
    ready_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    check("bp_accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset one cycle after accept: the pending result must vanish.
    send(16'd200, 16'd13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rem_out", 32'(rem_out), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    // Randomized operands with random consumer backpressure.
    ready_mode = 1;
    repeat (40) begin
      ra = DW'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = DW'($urandom_range(1, 15));
        default: rb = DW'($urandom);
      endcase
      send(ra, rb);
    end
    ready_mode = 0;
    wait_idle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
